// File: rtl/ili9341_frame_sequencer.sv
// ILI9341 frame sequencer: LCD hardware reset, init array, then a
// frame loop streaming RGB565 pixels through one shared SPI sender.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   i_enable                 frame loop runs while high
//   o_send_comm_ena/o_command  start + array select to send_command
//   i_comm_array_sent        command array finished pulse
//   i_cmd_*/o_cmd_sent       command-path byte request / done
//   i_pix_valid/i_pix_data/o_pix_ready  pixel source handshake
//   o_spi_*/i_spi_done       byte-level SPI sender
//   o_lcd_rst                LCD reset, active low
//   o_frame_done/o_init_done status
`timescale 1ns/1ps
module ili9341_frame_sequencer #(
  parameter int DW           = 8,
  parameter int H_RES        = 240,
  parameter int V_RES        = 320,
  parameter int RST_LOW_CYC  = 1250,
  parameter int RST_WAIT_CYC = 625000,
  parameter int SLP_WAIT_CYC = 15000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_enable,
  output logic          o_send_comm_ena,
  output logic          o_command,
  input  logic          i_comm_array_sent,
  input  logic          i_cmd_send,
  input  logic [DW-1:0] i_cmd_data,
  input  logic          i_cmd_dc,
  input  logic          i_cmd_cs,
  output logic          o_cmd_sent,
  input  logic          i_pix_valid,
  input  logic [15:0]   i_pix_data,
  output logic          o_pix_ready,
  output logic          o_spi_send,
  output logic [DW-1:0] o_spi_data,
  output logic          o_spi_dc,
  output logic          o_spi_cs,
  input  logic          i_spi_done,
  output logic          o_lcd_rst,
  output logic          o_frame_done,
  output logic          o_init_done
);

  localparam logic INI_COMM  = 1'b0;
  localparam logic LOOP_COMM = 1'b1;

  localparam int NPIX  = H_RES * V_RES;
  localparam int MAX_A = (RST_LOW_CYC > RST_WAIT_CYC) ?
                         RST_LOW_CYC : RST_WAIT_CYC;
  localparam int MAX_C = (MAX_A > SLP_WAIT_CYC) ?
                         MAX_A : SLP_WAIT_CYC;
  localparam int CW    = $clog2(MAX_C) + 1;
  localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [CW-1:0] LOW_LAST  = CW'(RST_LOW_CYC - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(RST_WAIT_CYC - 1);
  localparam logic [CW-1:0] SLP_LAST  = CW'(SLP_WAIT_CYC - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(NPIX - 1);

  typedef enum logic [3:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_INIT_START,
    S_INIT_RUN,
    S_SLP_WAIT,
    S_IDLE,
    S_LOOP_START,
    S_LOOP_RUN,
    S_PIX_LOAD,
    S_PIX_HI,
    S_PIX_LO,
    S_FRAME_DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] pix_cnt_q;
  logic [15:0]   pix_q;
  logic          cmd_q;
  logic          init_q;

  logic pix_load;
  logic pix_dec;
  logic pix_cap;
  logic init_set;
  logic cnt_run;

  // Delay counter only advances in the timed states and
  // restarts from zero on every state change.
  assign cnt_run = (state_q == S_RST_LOW)  ||
                   (state_q == S_RST_WAIT) ||
                   (state_q == S_SLP_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RST_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_run) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_q <= '0;
      pix_q     <= '0;
    end else begin
      if (pix_load) begin
        pix_cnt_q <= PIX_LAST;
      end else if (pix_dec) begin
        pix_cnt_q <= pix_cnt_q - PW'(1);
      end
      if (pix_cap) begin
        pix_q <= i_pix_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q  <= INI_COMM;
      init_q <= 1'b0;
    end else begin
      if (state_q == S_INIT_START) begin
        cmd_q <= INI_COMM;
      end else if (state_q == S_LOOP_START) begin
        cmd_q <= LOOP_COMM;
      end
      if (init_set) begin
        init_q <= 1'b1;
      end
    end
  end

  assign o_command   = (state_q == S_LOOP_START) ?
                       LOOP_COMM : cmd_q;
  assign o_lcd_rst   = (state_q != S_RST_LOW);
  assign o_init_done = init_q;

  always_comb begin
    state_d         = state_q;
    pix_load        = 1'b0;
    pix_dec         = 1'b0;
    pix_cap         = 1'b0;
    init_set        = 1'b0;
    o_send_comm_ena = 1'b0;
    o_spi_send      = 1'b0;
    o_spi_data      = '0;
    o_spi_dc        = 1'b1;
    o_spi_cs        = 1'b1;
    o_cmd_sent      = 1'b0;
    o_pix_ready     = 1'b0;
    o_frame_done    = 1'b0;
    unique case (state_q)
      S_RST_LOW: begin
        if (cnt_q == LOW_LAST) begin
          state_d = S_RST_WAIT;
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_INIT_START;
        end
      end
      S_INIT_START: begin
        o_send_comm_ena = 1'b1;
        state_d         = S_INIT_RUN;
      end
      S_INIT_RUN: begin
        o_spi_send = i_cmd_send;
        o_spi_data = i_cmd_data;
        o_spi_dc   = i_cmd_dc;
        o_spi_cs   = i_cmd_cs;
        o_cmd_sent = i_spi_done;
        if (i_comm_array_sent) begin
          state_d = S_SLP_WAIT;
        end
      end
      S_SLP_WAIT: begin
        if (cnt_q == SLP_LAST) begin
          init_set = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_IDLE: begin
        if (i_enable) begin
          state_d = S_LOOP_START;
        end
      end
      S_LOOP_START: begin
        o_send_comm_ena = 1'b1;
        state_d         = S_LOOP_RUN;
      end
      S_LOOP_RUN: begin
        o_spi_send = i_cmd_send;
        o_spi_data = i_cmd_data;
        o_spi_dc   = i_cmd_dc;
        o_spi_cs   = i_cmd_cs;
        o_cmd_sent = i_spi_done;
        if (i_comm_array_sent) begin
          pix_load = 1'b1;
          state_d  = S_PIX_LOAD;
        end
      end
      // CS stays low across pixel stalls so the RAMWR
      // stream is never broken mid-frame.
      S_PIX_LOAD: begin
        o_pix_ready = 1'b1;
        o_spi_cs    = 1'b0;
        if (i_pix_valid) begin
          pix_cap = 1'b1;
          state_d = S_PIX_HI;
        end
      end
      S_PIX_HI: begin
        o_spi_send = 1'b1;
        o_spi_data = DW'(pix_q[15:8]);
        o_spi_cs   = 1'b0;
        if (i_spi_done) begin
          state_d = S_PIX_LO;
        end
      end
      S_PIX_LO: begin
        o_spi_send = 1'b1;
        o_spi_data = DW'(pix_q[7:0]);
        o_spi_cs   = 1'b0;
        if (i_spi_done) begin
          if (pix_cnt_q == '0) begin
            state_d = S_FRAME_DONE;
          end else begin
            pix_dec = 1'b1;
            state_d = S_PIX_LOAD;
          end
        end
      end
      S_FRAME_DONE: begin
        o_frame_done = 1'b1;
        state_d      = i_enable ? S_LOOP_START : S_IDLE;
      end
      default: begin
        state_d = S_RST_LOW;
      end
    endcase
  end

endmodule

// File: tb/tb_ili9341_frame_sequencer.sv
// Bench for ili9341_frame_sequencer: reset/init timing, command
// mux table, pixel frames against a byte-stream model, reset replay.
`timescale 1ns/1ps
module tb_ili9341_frame_sequencer;

  localparam int DW   = 8;
  localparam int NPIX = 4;

  logic          clk;
  logic          rst;
  logic          i_enable;
  logic          o_send_comm_ena;
  logic          o_command;
  logic          i_comm_array_sent;
  logic          cmd_send;
  logic [DW-1:0] cmd_data;
  logic          cmd_dc;
  logic          cmd_cs;
  logic          o_cmd_sent;
  logic          i_pix_valid;
  logic [15:0]   i_pix_data;
  logic          o_pix_ready;
  logic          o_spi_send;
  logic [DW-1:0] o_spi_data;
  logic          o_spi_dc;
  logic          o_spi_cs;
  logic          i_spi_done;
  logic          o_lcd_rst;
  logic          o_frame_done;
  logic          o_init_done;

  logic cmd_done;
  logic resp_done;
  logic resp_en;
  assign i_spi_done = cmd_done | resp_done;

  int n_tests;
  int n_fail;

  logic [9:0]  byte_q[$];
  logic [15:0] fpix [NPIX];

  typedef struct {
    logic          send;
    logic [DW-1:0] data;
    logic          dc;
    logic          cs;
    logic          done;
    logic [11:0]   exp;
  } vec_t;

  vec_t tbl [7];

  ili9341_frame_sequencer #(
    .DW(DW), .H_RES(2), .V_RES(2),
    .RST_LOW_CYC(4), .RST_WAIT_CYC(8), .SLP_WAIT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_enable(i_enable),
    .o_send_comm_ena(o_send_comm_ena),
    .o_command(o_command),
    .i_comm_array_sent(i_comm_array_sent),
    .i_cmd_send(cmd_send),
    .i_cmd_data(cmd_data),
    .i_cmd_dc(cmd_dc),
    .i_cmd_cs(cmd_cs),
    .o_cmd_sent(o_cmd_sent),
    .i_pix_valid(i_pix_valid),
    .i_pix_data(i_pix_data),
    .o_pix_ready(o_pix_ready),
    .o_spi_send(o_spi_send),
    .o_spi_data(o_spi_data),
    .o_spi_dc(o_spi_dc),
    .o_spi_cs(o_spi_cs),
    .i_spi_done(i_spi_done),
    .o_lcd_rst(o_lcd_rst),
    .o_frame_done(o_frame_done),
    .o_init_done(o_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SPI sender model: acknowledges each requested byte after a
  // random latency and logs {cs, dc, data} as seen on the bus.
  initial begin : responder
    int wait_left;
    wait_left = 0;
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_done) begin
        resp_done = 1'b0;
      end else if (resp_en && o_spi_send) begin
        if (wait_left == 0) begin
          resp_done = 1'b1;
          byte_q.push_back({o_spi_cs, o_spi_dc, o_spi_data});
          wait_left = int'($urandom_range(3, 0));
        end else begin
          wait_left--;
        end
      end
    end
  end

  task automatic idle_cmd();
    cmd_send = 1'b0;
    cmd_data = '0;
    cmd_dc   = 1'b1;
    cmd_cs   = 1'b1;
    cmd_done = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    cmd_send = tbl[i].send;
    cmd_data = tbl[i].data;
    cmd_dc   = tbl[i].dc;
    cmd_cs   = tbl[i].cs;
    cmd_done = tbl[i].done;
    #1;
    check($sformatf("mux_vec%0d", i),
          32'({o_spi_send, o_spi_data, o_spi_dc,
               o_spi_cs, o_cmd_sent}),
          32'(tbl[i].exp));
  endtask

  // Called at the negedge where rst is released; returns at the
  // 16th following negedge with the DUT waiting in the init array.
  task automatic watch_reset(input string tag);
    int first_hi;
    int first_ena;
    int n_ena;
    int cmd_at;
    first_hi  = -1;
    first_ena = -1;
    n_ena     = 0;
    cmd_at    = -1;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (o_lcd_rst && first_hi < 0) first_hi = k;
      if (o_send_comm_ena) begin
        n_ena++;
        if (first_ena < 0) begin
          first_ena = k;
          cmd_at    = int'(o_command);
        end
      end
      @(negedge clk);
    end
    check({tag, "_lcd_rst_low_cycles"}, 32'(first_hi), 32'd4);
    check({tag, "_init_ena_cycle"}, 32'(first_ena), 32'd12);
    check({tag, "_init_ena_count"}, 32'(n_ena), 32'd1);
    check({tag, "_init_command"}, 32'(cmd_at), 32'd0);
  endtask

  // Entered at a negedge in the loop-array phase; leaves at the
  // negedge after the frame_done follow-up sample.
  task automatic run_frame(input string tag,
                           input int stall_after,
                           input int stall_len,
                           input bit drop_en);
    logic [DW-1:0] d;
    logic          dcb;
    int            pidx;
    int            stall_left;
    int            nfd;
    int            nbytes;
    int            viol;
    logic [9:0]    exp_b;
    logic [9:0]    act_b;
    d   = DW'($urandom);
    dcb = 1'($urandom);
    cmd_send = 1'b1;
    cmd_data = d;
    cmd_dc   = dcb;
    cmd_cs   = 1'b0;
    cmd_done = 1'b1;
    #1;
    check({tag, "_loop_mux"},
          32'({o_spi_send, o_spi_data, o_spi_dc,
               o_spi_cs, o_cmd_sent}),
          32'({1'b1, d, dcb, 1'b0, 1'b1}));
    @(negedge clk);
    idle_cmd();
    i_comm_array_sent = 1'b1;
    @(negedge clk);
    i_comm_array_sent = 1'b0;
    byte_q.delete();
    resp_en    = 1'b1;
    pidx       = 0;
    stall_left = 0;
    nfd        = 0;
    nbytes     = -1;
    viol       = 0;
    for (int k = 0; k < 600 && nfd == 0; k++) begin
      if (o_frame_done) begin
        nfd    = 1;
        nbytes = byte_q.size();
      end else begin
        if (o_cmd_sent) viol++;
        if (o_spi_send && o_spi_cs) viol++;
        if (o_pix_ready) begin
          if (o_spi_cs !== 1'b0 || o_spi_send !== 1'b0) viol++;
          if (stall_left > 0) begin
            stall_left--;
            i_pix_valid = 1'b0;
            i_pix_data  = 16'($urandom);
          end else if (pidx < NPIX) begin
            i_pix_valid = 1'b1;
            i_pix_data  = fpix[pidx];
            pidx++;
            if (pidx == stall_after) stall_left = stall_len;
            if (drop_en && pidx == 2) i_enable = 1'b0;
          end else begin
            i_pix_valid = 1'b0;
          end
        end else begin
          i_pix_valid = 1'($urandom);
          i_pix_data  = 16'($urandom);
        end
        @(negedge clk);
      end
    end
    resp_en     = 1'b0;
    i_pix_valid = 1'b0;
    check({tag, "_frame_done_seen"}, 32'(nfd), 32'd1);
    check({tag, "_bytes_at_done"}, 32'(nbytes), 32'd8);
    check({tag, "_pixel_phase_violations"}, 32'(viol), 32'd0);
    for (int i = 0; i < 2 * NPIX; i++) begin
      exp_b = (i % 2 == 0) ? {2'b01, fpix[i / 2][15:8]}
                           : {2'b01, fpix[i / 2][7:0]};
      act_b = (i < byte_q.size()) ? byte_q[i] : 10'h3ff;
      check($sformatf("%s_byte%0d", tag, i),
            32'(act_b), 32'(exp_b));
    end
    @(negedge clk);
    check({tag, "_after_frame"},
          32'({o_frame_done, o_spi_cs, o_send_comm_ena, o_command}),
          32'({1'b0, 1'b1, i_enable, 1'b1}));
    @(negedge clk);
  endtask

  initial begin : main
    int lowcnt;
    int seen;
    int n_ena;
    int viol;
    n_tests = 0;
    n_fail  = 0;

    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0,
               {1'b1, 8'h11, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1,
               {1'b1, 8'h11, 1'b0, 1'b0, 1'b1}};
    tbl[2] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b0,
               {1'b0, 8'hA5, 1'b1, 1'b1, 1'b0}};
    tbl[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1,
               {1'b1, 8'h3C, 1'b1, 1'b0, 1'b1}};
    tbl[4] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1,
               {1'b0, 8'h00, 1'b1, 1'b1, 1'b0}};
    tbl[5] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0,
               {1'b0, 8'h00, 1'b1, 1'b1, 1'b0}};
    tbl[6] = '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b1,
               {1'b0, 8'h00, 1'b1, 1'b1, 1'b0}};

    rst               = 1'b0;
    resp_en           = 1'b0;
    i_enable          = 1'b1;
    i_comm_array_sent = 1'b0;
    i_pix_valid       = 1'b1;
    i_pix_data        = 16'hBEEF;
    cmd_send          = 1'b1;
    cmd_data          = 8'h77;
    cmd_dc            = 1'b0;
    cmd_cs            = 1'b0;
    cmd_done          = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_values",
          32'({o_lcd_rst, o_spi_send, o_spi_data, o_spi_dc,
               o_spi_cs, o_send_comm_ena, o_command, o_pix_ready,
               o_frame_done, o_init_done, o_cmd_sent}),
          32'({1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0}));

    @(negedge clk);
    idle_cmd();
    i_enable    = 1'b0;
    i_pix_valid = 1'b0;
    rst         = 1'b1;
    watch_reset("por");

    for (int i = 0; i < 4; i++) begin
      apply_vec(i);
      @(negedge clk);
    end
    idle_cmd();

    i_comm_array_sent = 1'b1;
    @(negedge clk);
    i_comm_array_sent = 1'b0;
    i_enable          = 1'b1;
    lowcnt = 0;
    seen   = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      if (o_init_done) seen = 1;
      else lowcnt++;
      if (k < 3) apply_vec(4 + k);
      else idle_cmd();
      i_comm_array_sent = (k == 5);
      if (seen == 0) @(negedge clk);
    end
    i_comm_array_sent = 1'b0;
    check("init_done_seen", 32'(seen), 32'd1);
    check("init_done_delay", 32'(lowcnt), 32'd16);
    check("idle_no_ena",
          32'({o_send_comm_ena, o_spi_cs, o_spi_send}),
          32'({1'b0, 1'b1, 1'b0}));
    @(negedge clk);
    check("loop_start",
          32'({o_send_comm_ena, o_command}),
          32'({1'b1, 1'b1}));
    @(negedge clk);

    fpix[0] = 16'hF800;
    fpix[1] = 16'h07E0;
    fpix[2] = 16'h001F;
    fpix[3] = 16'hFFFF;
    run_frame("frame1", 0, 0, 1'b0);
    check("frame2_ena", 32'(o_send_comm_ena), 32'd0);
    run_frame("frame2_stall", 2, 20, 1'b0);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NPIX; i++) fpix[i] = 16'($urandom);
      run_frame($sformatf("rnd%0d", f),
                int'($urandom_range(3, 0)),
                int'($urandom_range(10, 1)), 1'b0);
    end

    for (int i = 0; i < NPIX; i++) fpix[i] = 16'($urandom);
    run_frame("drop_en", 0, 0, 1'b1);
    n_ena = 0;
    viol  = 0;
    for (int k = 0; k < 10; k++) begin
      if (o_send_comm_ena) n_ena++;
      if (o_spi_cs !== 1'b1 || o_spi_send !== 1'b0) viol++;
      if (o_pix_ready) viol++;
      @(negedge clk);
    end
    check("idle_after_drop_ena", 32'(n_ena), 32'd0);
    check("idle_after_drop_bus", 32'(viol), 32'd0);

    i_enable = 1'b1;
    @(negedge clk);
    check("restart_loop_start", 32'(o_send_comm_ena), 32'd1);
    @(negedge clk);
    i_comm_array_sent = 1'b1;
    @(negedge clk);
    i_comm_array_sent = 1'b0;
    check("midrst_ready", 32'(o_pix_ready), 32'd1);
    i_pix_valid = 1'b1;
    i_pix_data  = 16'h1234;
    @(negedge clk);
    i_pix_valid = 1'b0;
    #1;
    check("midrst_hi_byte",
          32'({o_spi_send, o_spi_cs, o_spi_data}),
          32'({1'b1, 1'b0, 8'h12}));
    rst = 1'b0;
    #1;
    check("midrst_immediate",
          32'({o_lcd_rst, o_spi_cs, o_spi_send,
               o_init_done, o_pix_ready, o_command}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    rst = 1'b1;
    watch_reset("midrst");
    check("midrst_init_done_clear", 32'(o_init_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ili9341_frame_sequencer.md
Name: ili9341_frame_sequencer

Overview:
- Top-level scheduler for the ILI9341 SPI path. Runs three phases: LCD hardware reset, init command array, then a repeating frame loop.
- Each frame loop sends the loop command array (address window plus memory write), then streams H_RES*V_RES 16-bit pixels.
- Owns the single byte-level SPI sender and arbitrates it between the command sequencer (send_command) and the pixel source.

Parameters:
- DW, 8: SPI byte width.
- H_RES, 240: pixels per line.
- V_RES, 320: lines per frame.
- RST_LOW_CYC, 1250: cycles o_lcd_rst is held low.
- RST_WAIT_CYC, 625000: cycles waited after o_lcd_rst rises, before init.
- SLP_WAIT_CYC, 15000000: cycles waited after the init array completes (sleep-out settle).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_enable  in  1  frame loop runs while high.
- o_send_comm_ena  out  1  start pulse to send_command.
- o_command  out  1  array select to send_command: INI_COMM or LOOP_COMM.
- i_comm_array_sent  in  1  1-cycle pulse from send_command when its array is finished.
- i_cmd_send  in  1  command-path byte request.
- i_cmd_data  in  DW  command-path byte.
- i_cmd_dc  in  1  command-path D/C.
- i_cmd_cs  in  1  command-path CS.
- o_cmd_sent  out  1  byte-done pulse routed back to send_command.
- i_pix_valid  in  1  pixel source has data.
- i_pix_data  in  16  RGB565 pixel.
- o_pix_ready  out  1  pixel accepted (transfer = valid && ready).
- o_spi_send  out  1  byte request to the SPI sender; held high until done.
- o_spi_data  out  DW  byte to send.
- o_spi_dc  out  1  D/C to the SPI sender.
- o_spi_cs  out  1  CS to the SPI sender.
- i_spi_done  in  1  1-cycle pulse when the SPI sender finishes a byte.
- o_lcd_rst  out  1  LCD hardware reset, active low.
- o_frame_done  out  1  1-cycle pulse after the last pixel byte of a frame.
- o_init_done  out  1  level; high once the init sequence completes.

Behaviour:
- Reset values: o_lcd_rst=0, o_spi_send=0, o_spi_data=0, o_spi_dc=1, o_spi_cs=1, o_send_comm_ena=0, o_command=INI_COMM, o_pix_ready=0, o_frame_done=0, o_init_done=0, o_cmd_sent=0; state = RST_LOW; delay counter cleared.
- Delay counter width: $clog2 of the largest *_CYC parameter, plus 1. Pixel counter width: $clog2(H_RES*V_RES).
- RST_LOW: o_lcd_rst=0 for exactly RST_LOW_CYC cycles -> RST_WAIT.
- RST_WAIT: o_lcd_rst=1 for RST_WAIT_CYC cycles -> INIT_START.
- INIT_START: o_send_comm_ena=1 for one cycle, o_command=INI_COMM -> INIT_RUN.
- INIT_RUN: command path owns SPI. o_spi_* = i_cmd_*; o_cmd_sent = i_spi_done. On i_comm_array_sent -> SLP_WAIT.
- SLP_WAIT: SLP_WAIT_CYC cycles -> IDLE, and o_init_done is set and stays high until reset.
- IDLE: o_spi_cs=1, o_spi_send=0. If i_enable -> LOOP_START.
- LOOP_START: one-cycle o_send_comm_ena, o_command=LOOP_COMM -> LOOP_RUN. o_command holds LOOP_COMM until the next INIT.
- LOOP_RUN: same muxing as INIT_RUN. On i_comm_array_sent -> PIX_LOAD, and the pixel counter loads H_RES*V_RES-1.
- PIX_LOAD: o_pix_ready=1, o_spi_cs=0, o_spi_dc=1, o_spi_send=0. When i_pix_valid, capture i_pix_data -> PIX_HI. If i_pix_valid stays low, hold indefinitely with CS low.
- PIX_HI: o_spi_send=1, o_spi_data=pix[15:8], dc=1, cs=0. On i_spi_done -> PIX_LO.
- PIX_LO: o_spi_send=1, o_spi_data=pix[7:0]. On i_spi_done: if counter==0 -> FRAME_DONE, else decrement -> PIX_LOAD.
- FRAME_DONE: o_frame_done=1 for one cycle, cs=1. If i_enable -> LOOP_START, else -> IDLE.
- Arbitration: command inputs are ignored outside INIT_RUN/LOOP_RUN. o_cmd_sent=0 outside those states. i_spi_done is ignored in states not requesting a byte.
- i_comm_array_sent outside INIT_RUN/LOOP_RUN is ignored.
- i_enable falling mid-frame: the current frame completes, then the block returns to IDLE.
- Reset asserted mid-operation: immediate return to reset values, and the full LCD reset/init sequence is repeated.

Test Plan:
- Common parameters: RST_LOW_CYC=4, RST_WAIT_CYC=8, SLP_WAIT_CYC=16, H_RES=2, V_RES=2.
- Release rst -> o_lcd_rst low for exactly 4 cycles, high; o_send_comm_ena pulses 8 cycles later with o_command=INI_COMM.
- Command mux: in INIT_RUN drive i_cmd_data=0x11, i_cmd_dc=0, i_cmd_cs=0, i_cmd_send=1, then pulse i_spi_done -> o_spi_data=0x11, dc=0, cs=0 mirrored; o_cmd_sent pulses the same cycle as i_spi_done.
- Pulse i_comm_array_sent -> o_init_done rises exactly 16 cycles later; with i_enable=1, next cycle o_send_comm_ena pulses with o_command=LOOP_COMM.
- Frame: after the loop array completes, feed pixels 0xF800, 0x07E0, 0x001F, 0xFFFF with the done-responder -> SPI bytes F8,00,07,E0,00,1F,FF,FF with dc=1, cs=0; o_frame_done pulses once after the 8th byte; cs returns to 1.
- Stall: hold i_pix_valid=0 for 20 cycles mid-frame -> o_spi_send=0, cs stays 0, byte order is unaffected.
- Drop i_enable during pixel 2 -> frame finishes, the block enters IDLE, and no further o_send_comm_ena. Assert rst mid-frame -> o_lcd_rst=0 and cs=1 immediately, and the 4/8-cycle reset sequence replays.
